// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter for the write port of a synchronous FIFO.
// Each producer offers a valid/ready stream. The winner owns the write port
// for a burst of up to MAX_BURST accepted beats. The FIFO full flag stalls the
// owner without releasing it. If the owner drops valid, its ownership ends that cycle.
module fifo_write_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               i_req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    i_req_data,
  output logic [NUM_REQ-1:0]               o_req_ready,
  output logic [NUM_REQ-1:0]               o_gnt,
  input  logic                             i_full,
  output logic                             o_wen,
  output logic [DATA_WIDTH-1:0]            o_wdata
);

  localparam int unsigned OwnerW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW   = $clog2(MAX_BURST) + 1;

  localparam logic [CntW-1:0]   LastBeat   = CntW'(MAX_BURST - 1);
  // Last owner starts as the highest index so that producer 0 has first priority.
  localparam logic [OwnerW-1:0] ResetOwner = OwnerW'(NUM_REQ - 1);

  typedef enum logic {StIdle, StOwn} state_e;

  state_e              r_state;
  logic [OwnerW-1:0]   r_owner;
  logic [CntW-1:0]     r_beat_cnt;
  logic [NUM_REQ-1:0]  r_gnt;

  logic                w_busy;
  logic                w_owner_valid;
  logic                w_accept;
  logic                w_release;
  logic                w_found;
  logic [OwnerW-1:0]   w_winner;
  logic [OwnerW-1:0]   w_idx;
  logic [NUM_REQ-1:0]  w_winner_oh;
  logic [DATA_WIDTH-1:0] w_wdata;

  assign w_busy        = (r_state == StOwn);
  assign w_owner_valid = i_req_valid[r_owner];
  assign w_accept      = w_busy & w_owner_valid & ~i_full;
  // A full stall blocks accept, so a burst cannot end while the FIFO is full.
  assign w_release     = w_busy & ((w_accept & (r_beat_cnt == LastBeat)) | ~w_owner_valid);

  // Round-robin search starting just after the last owner, wrapping around.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_owner;
    w_idx    = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_idx = OwnerW'((int'(r_owner) + int'(k)) % int'(NUM_REQ));
      if (!w_found && i_req_valid[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  // One-hot decode of the arbitration winner for the registered grant.
  always_comb begin
    w_winner_oh = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_winner_oh[i] = (w_winner == OwnerW'(i));
    end
  end

  // Select the owner's data slice; zero while idle.
  always_comb begin
    w_wdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_busy && (r_owner == OwnerW'(i))) begin
        w_wdata = i_req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Ownership FSM: arbitrate when idle or releasing, otherwise count accepted beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_owner    <= ResetOwner;
      r_beat_cnt <= '0;
      r_gnt      <= '0;
    end else if (!w_busy || w_release) begin
      if (w_found) begin
        r_state    <= StOwn;
        r_owner    <= w_winner;
        r_beat_cnt <= '0;
        r_gnt      <= w_winner_oh;
      end else begin
        // Owner is kept as the round-robin pointer for the next search.
        r_state    <= StIdle;
        r_beat_cnt <= '0;
        r_gnt      <= '0;
      end
    end else if (w_accept) begin
      r_beat_cnt <= r_beat_cnt + CntW'(1);
    end
  end

  assign o_gnt       = r_gnt;
  assign o_req_ready = r_gnt & {NUM_REQ{~i_full}};
  assign o_wen       = w_accept;
  assign o_wdata     = w_wdata;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter (NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=4).
module tb_fifo_write_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic            full;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    gnt;
  logic            wen;
  logic [DW-1:0]   wdata;

  int checks = 0;
  int errors = 0;

  // Reference model state: who owns the port and how many beats it has written.
  int m_busy;
  int m_owner;
  int m_cnt;

  fifo_write_arbiter #(
    .NUM_REQ   (N),
    .DATA_WIDTH(DW),
    .MAX_BURST (MB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_req_valid(req_valid),
    .i_req_data (req_data),
    .o_req_ready(req_ready),
    .o_gnt      (gnt),
    .i_full     (full),
    .o_wen      (wen),
    .o_wdata    (wdata)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] exp_gnt();
    logic [N-1:0] g;
    g = '0;
    if (rst_n === 1'b1 && m_busy != 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  function automatic logic exp_wen();
    return (rst_n === 1'b1) && (m_busy != 0) && (req_valid[m_owner] === 1'b1) && (full === 1'b0);
  endfunction

  function automatic logic [N-1:0] exp_ready();
    return full ? '0 : exp_gnt();
  endfunction

  function automatic logic [DW-1:0] exp_wdata();
    if (rst_n === 1'b1 && m_busy != 0) return req_data[m_owner*DW +: DW];
    return '0;
  endfunction

  // Advance the model by one clock using the inputs presented in that cycle.
  task automatic model_update();
    bit acc;
    bit rel;
    int w;
    if (rst_n !== 1'b1) begin
      m_busy  = 0;
      m_owner = N - 1;
      m_cnt   = 0;
    end else begin
      acc = exp_wen();
      rel = (m_busy != 0) && ((acc && m_cnt == MB - 1) || (req_valid[m_owner] !== 1'b1));
      if (m_busy == 0 || rel) begin
        w = -1;
        for (int k = 1; k <= N; k++) begin
          if (w < 0 && req_valid[(m_owner + k) % N] === 1'b1) w = (m_owner + k) % N;
        end
        if (w >= 0) begin
          m_busy  = 1;
          m_owner = w;
          m_cnt   = 0;
        end else begin
          m_busy = 0;
        end
      end else if (acc) begin
        m_cnt = m_cnt + 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    full      = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_valid = N'($urandom);
      req_data  = $urandom;
      full      = 1'(($urandom));
      #4;
      checks++;
      if (gnt !== '0 || wen !== 1'b0 || req_ready !== '0 || wdata !== '0) begin
        errors++;
        $display("FAIL reset_hold cyc %0d: got gnt=%b wen=%b rdy=%b wdata=%h required all 0",
                 i, gnt, wen, req_ready, wdata);
      end
      tick();
    end
    rst_n     = 1'b1;
    req_valid = '0;
    full      = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #4;
      checks++;
      if (gnt !== '0 || wen !== 1'b0 || req_ready !== '0 || wdata !== '0) begin
        errors++;
        $display("FAIL reset_release cyc %0d: got gnt=%b wen=%b rdy=%b wdata=%h required all 0",
                 i, gnt, wen, req_ready, wdata);
      end
      tick();
    end
  endtask

  task automatic test_single_streamer();
    do_reset();
    req_valid = 4'b0100;
    req_data  = '0;
    req_data[23:16] = 8'h20;
    #4;
    checks++;
    if (gnt !== 4'b0000 || wen !== 1'b0) begin
      errors++;
      $display("FAIL stream_first: got gnt=%b wen=%b required 0000/0", gnt, wen);
    end
    tick();
    for (int i = 0; i < 6; i++) begin
      req_data[23:16] = 8'(8'h20 + i);
      #4;
      checks++;
      if (gnt !== 4'b0100 || wen !== 1'b1 || wdata !== 8'(8'h20 + i)) begin
        errors++;
        $display("FAIL stream_beat %0d: got gnt=%b wen=%b wdata=%h required 0100/1/%h",
                 i, gnt, wen, wdata, 8'(8'h20 + i));
      end
      tick();
    end
    req_valid = '0;
    #4;
    checks++;
    if (wen !== 1'b0) begin
      errors++;
      $display("FAIL stream_drop: got wen=%b required 0", wen);
    end
    tick();
    #4;
    checks++;
    if (gnt !== 4'b0000) begin
      errors++;
      $display("FAIL stream_idle: got gnt=%b required 0000", gnt);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] eg;
    do_reset();
    req_valid = 4'b1111;
    req_data  = 32'h83828180;
    #4;
    checks++;
    if (gnt !== 4'b0000) begin
      errors++;
      $display("FAIL rr_first: got gnt=%b required 0000", gnt);
    end
    tick();
    for (int i = 0; i < 20; i++) begin
      eg = 4'b0001 << ((i / 4) % 4);
      #4;
      checks++;
      if (gnt !== eg || wen !== 1'b1 || wdata !== 8'(8'h80 + (i / 4) % 4)) begin
        errors++;
        $display("FAIL rr_cycle %0d: got gnt=%b wen=%b wdata=%h required %b/1/%h",
                 i, gnt, wen, wdata, eg, 8'(8'h80 + (i / 4) % 4));
      end
      tick();
    end
  endtask

  task automatic test_full_stall();
    do_reset();
    req_valid = 4'b0110;
    req_data  = 32'h00441100;
    tick();
    for (int i = 0; i < 7; i++) begin
      full = (i >= 2 && i < 5);
      #4;
      checks++;
      if (gnt !== 4'b0010 || wen !== !full || req_ready !== (full ? 4'b0000 : 4'b0010)
          || wdata !== 8'h11) begin
        errors++;
        $display("FAIL stall_cycle %0d: got gnt=%b wen=%b rdy=%b wdata=%h required 0010/%b/%b/11",
                 i, gnt, wen, req_ready, wdata, !full, (full ? 4'b0000 : 4'b0010));
      end
      tick();
    end
    #4;
    checks++;
    if (gnt !== 4'b0100 || wen !== 1'b1 || wdata !== 8'h44) begin
      errors++;
      $display("FAIL stall_release: got gnt=%b wen=%b wdata=%h required 0100/1/44",
               gnt, wen, wdata);
    end
    tick();
  endtask

  task automatic test_withdrawal();
    do_reset();
    req_valid = 4'b1001;
    req_data  = 32'hD30000A0;
    tick();
    for (int i = 0; i < 2; i++) begin
      #4;
      checks++;
      if (gnt !== 4'b0001 || wen !== 1'b1 || wdata !== 8'hA0) begin
        errors++;
        $display("FAIL wd_beat %0d: got gnt=%b wen=%b wdata=%h required 0001/1/a0",
                 i, gnt, wen, wdata);
      end
      tick();
    end
    req_valid = 4'b1000;
    #4;
    checks++;
    if (wen !== 1'b0 || gnt !== 4'b0001) begin
      errors++;
      $display("FAIL wd_bubble: got gnt=%b wen=%b required 0001/0", gnt, wen);
    end
    tick();
    #4;
    checks++;
    if (gnt !== 4'b1000 || wen !== 1'b1 || wdata !== 8'hD3) begin
      errors++;
      $display("FAIL wd_handover: got gnt=%b wen=%b wdata=%h required 1000/1/d3",
               gnt, wen, wdata);
    end
    tick();
  endtask

  task automatic test_mid_burst_reset();
    do_reset();
    req_valid = 4'b0100;
    req_data  = 32'h005A0000;
    tick();
    tick();
    #4;
    checks++;
    if (gnt !== 4'b0100 || wen !== 1'b1) begin
      errors++;
      $display("FAIL mbr_beat2: got gnt=%b wen=%b required 0100/1", gnt, wen);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (gnt !== '0 || wen !== 1'b0 || req_ready !== '0 || wdata !== '0) begin
      errors++;
      $display("FAIL mbr_async: got gnt=%b wen=%b rdy=%b wdata=%h required all 0",
               gnt, wen, req_ready, wdata);
    end
    tick();
    req_valid = 4'b1111;
    rst_n     = 1'b1;
    #4;
    checks++;
    if (gnt !== 4'b0000) begin
      errors++;
      $display("FAIL mbr_idle: got gnt=%b required 0000", gnt);
    end
    tick();
    #4;
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL mbr_first_grant: got gnt=%b required 0001", gnt);
    end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++) req_valid[i] = ($urandom_range(0, 9) < 7);
      full     = ($urandom_range(0, 9) < 2);
      req_data = $urandom;
      #4;
      checks++;
      if (gnt !== exp_gnt() || req_ready !== exp_ready() || wen !== exp_wen()
          || wdata !== exp_wdata()) begin
        errors++;
        $display("FAIL random cyc %0d: got gnt=%b rdy=%b wen=%b wdata=%h required %b/%b/%b/%h",
                 c, gnt, req_ready, wen, wdata, exp_gnt(), exp_ready(), exp_wen(), exp_wdata());
      end
      tick();
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    full      = 1'b0;
    m_busy    = 0;
    m_owner   = N - 1;
    m_cnt     = 0;
    tick();
    test_reset();
    test_single_streamer();
    test_round_robin();
    test_full_stall();
    test_withdrawal();
    test_mid_burst_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin arbiter that shares the single write port of the synchronous FIFO (write/read pointer pair with full/empty flags) among NUM_REQ producers. Each producer presents a valid/ready stream. The arbiter grants exclusive ownership of the write port for bursts of up to MAX_BURST accepted beats, drives the FIFO write enable and write data, and back-pressures through per-requester ready. It sits directly in front of the FIFO write side.

## Interface
- NUM_REQ, 4: number of producers; legal range ≥ 2.
- DATA_WIDTH, 8: FIFO word width.
- MAX_BURST, 4: maximum accepted beats per grant; legal range ≥ 1.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req_valid  input  NUM_REQ  per-producer valid; bit i belongs to producer i.
- req_data  input  NUM_REQ*DATA_WIDTH  producer i data in bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  output  NUM_REQ  per-producer ready; equals gnt & {NUM_REQ{~full}} (combinational).
- gnt  output  NUM_REQ  registered one-hot current owner; all zero when idle.
- full  input  1  FIFO full flag.
- wen  output  1  FIFO write enable; equals accept (combinational).
- wdata  output  DATA_WIDTH  req_data slice of the owner; all zero when idle.

## Operation
- State registers:
  - busy (1 bit).
  - owner ($clog2(NUM_REQ) bits).
  - beat_cnt ($clog2(MAX_BURST)+1 bits).
- States:
  - IDLE (busy=0).
  - OWN (busy=1, gnt = one-hot(owner)).
- accept = busy & req_valid[owner] & ~full. A beat transfers on producer i when req_valid[i] & req_ready[i].
- release = busy & ((accept & beat_cnt==MAX_BURST-1) | ~req_valid[owner]).
- Arbitration runs in any cycle where busy=0 or release=1:
  - Candidates are the current-cycle req_valid bits.
  - Priority starts at (owner+1) mod NUM_REQ and wraps. owner holds the last owner, so it has the lowest priority.
  - If a winner exists: next busy=1, owner=winner, beat_cnt=0.
  - If no winner: next busy=0, and owner keeps its value for the next round-robin pointer.
- Otherwise, if accept, beat_cnt increments. With no accept, all state holds.
- full stalls without releasing. While full=1 the owner keeps gnt, beat_cnt holds, wen=0, and req_ready=0.
- A producer may drop req_valid at any time. If the owner drops it, ownership is released that cycle with no write.
- At burst end with no other valid requester, the same owner is re-granted with beat_cnt=0. It streams with no bubble.
- Starvation bound: a waiting requester is granted within (NUM_REQ-1) bursts, not counting cycles where full=1.

## Timing
- Reset values (async, immediate):
  - busy=0, owner=NUM_REQ-1 (first priority is producer 0), beat_cnt=0.
  - gnt=0, req_ready=0, wen=0, wdata=0.
- Idle to grant: req_valid rises in cycle t, gnt is set in cycle t+1, and the first write can occur in t+1 if full=0. Arbitration latency is 1 cycle.
- Burst-end handover: last beat in cycle t, new owner's gnt in t+1. wen can be high in both cycles (no bubble).
- Owner withdrawal: owner's req_valid is low in cycle t, so wen=0 in t and the new gnt appears in t+1. Exactly one bubble.
- full rising in cycle t forces wen=0 in the same cycle (combinational path from full to wen/req_ready). The FIFO therefore never receives a write while full.
- rst_n asserted mid-burst aborts the burst; no partial state survives. After deassertion, behaviour matches a fresh IDLE.
- Simultaneous events:
  - Release and a new request in the same cycle: arbitration uses that cycle's req_valid.
  - full=1 together with a burst-end condition: no accept, so no release; the burst continues.

## Test plan
All scenarios use NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=4.
- Reset: hold rst_n=0 with random req_valid -> gnt=0, wen=0, req_ready=0, wdata=0. Release reset with req_valid=0 -> outputs stay 0.
- Single streamer: req_valid=4'b0100 continuously, data 0x20..0x25 -> gnt=4'b0100 from the cycle after valid. wen stays high for 6 consecutive cycles and writes 0x20..0x25 in order. The re-grant at beat 4 causes no bubble.
- Round robin: req_valid=4'b1111 continuously -> gnt sequence 0001, 0010, 0100, 1000, 0001, each held exactly 4 cycles. wen stays high for 16+ cycles.
- Full stall: producer 1 owns, full=1 for 3 cycles after beat 2 -> wen=0 and gnt=4'b0010 hold for those cycles. Exactly 2 more beats follow once full=0, then release.
- Withdrawal: producer 0 drops req_valid after 2 beats while producer 3 is valid -> one cycle with wen=0, then gnt=4'b1000 and producer 3 data on wdata.
- Mid-burst reset: pulse rst_n low during producer 2's beat 2 -> outputs go to 0 immediately. After release with all requesters valid, the first grant is 4'b0001.
